// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx: buffers write strobes and launches one byte per
// frame, waiting for the transmitter's done pulse before releasing the next.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              osc_clk,
  input  logic              Reset,
  input  logic              i_Wr_DV,
  input  logic [7:0]        i_Wr_Byte,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Full,
  output logic              o_Empty,
  output logic              o_Overflow,
  input  logic              i_Clr_Ovf,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DONE = 2'd1,
    S_GAP       = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

  state_t            state;
  state_t            state_nxt;
  logic              launch;
  logic              wr_acc;
  logic [ADDR_W:0]   count_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [7:0]        mem [DEPTH];

  // State register.
  always_ff @(posedge osc_clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (launch)    state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (i_Tx_Done) state_nxt = S_GAP;
      S_GAP:                      state_nxt = S_IDLE;
      default:                    state_nxt = S_IDLE;
    endcase
  end

  // Output logic: the launch decision is also the pop for this cycle.
  always_comb begin
    launch    = (state == S_IDLE) && !o_Empty && !i_Tx_Active;
    dbg_state = state;
  end

  // A write into a full FIFO still fits when the same edge pops the head entry.
  always_comb begin
    wr_acc    = i_Wr_DV && (!o_Full || launch);
    count_nxt = o_Count;
    case ({wr_acc, launch})
      2'b10:   count_nxt = o_Count + ONE_CNT;
      2'b01:   count_nxt = o_Count - ONE_CNT;
      default: count_nxt = o_Count;
    endcase
  end

  always_ff @(posedge osc_clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_Count    <= '0;
      o_Full     <= 1'b0;
      o_Empty    <= 1'b1;
      o_Overflow <= 1'b0;
      o_Tx_DV    <= 1'b0;
      o_Tx_Byte  <= 8'h00;
    end else begin
      o_Count <= count_nxt;
      o_Full  <= (count_nxt == FULL_CNT);
      o_Empty <= (count_nxt == '0);
      o_Tx_DV <= launch;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (launch) begin
        rd_ptr    <= rd_ptr + 1'b1;
        o_Tx_Byte <= mem[rd_ptr];
      end
      // A dropped write wins over a simultaneous clear.
      if (i_Wr_DV && !wr_acc) o_Overflow <= 1'b1;
      else if (i_Clr_Ovf)     o_Overflow <= 1'b0;
    end
  end

  always_ff @(posedge osc_clk) begin
    if (wr_acc) mem[wr_ptr] <= i_Wr_Byte;
  end

endmodule
